// File: rtl/stage_mem_sram_ctrl.sv
// Memory stage: multi-cycle SRAM model for loads/stores plus the MEM/WB pipeline register.
// ready drops while an access is in flight so the upstream stages freeze.
module stage_mem_sram_ctrl #(
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbEnIn,
   input  logic        memREnIn,
   input  logic        memWEnIn,
   input  logic [31:0] aluResIn,
   input  logic [31:0] valRmIn,
   input  logic [3:0]  destIn,
   output logic        ready,
   output logic        wbEnOut,
   output logic        memREnOut,
   output logic [31:0] aluResOut,
   output logic [31:0] memDataOut,
   output logic [3:0]  destOut
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } memState_t;

   memState_t       state;
   memState_t       stateNext;
   logic [CW-1:0]   counter;
   logic [CW-1:0]   counterNext;

   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wordIdx;
   logic            req;
   logic            storeNow;
   logic            loadNow;

   // Byte address is rebased and truncated, so addresses past the end wrap back to word 0.
   assign wordIdx  = AW'((aluResIn - 32'(BASE_ADDR)) >> 2);
   assign req      = memREnIn | memWEnIn;
   assign ready    = ~req | (state == DONE);
   assign storeNow = (state == DONE) & memWEnIn;
   assign loadNow  = (state == DONE) & memREnIn & ~memWEnIn;

   // State and wait counter; reset aborts any access before it reaches DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         counter <= '0;
      end else begin
         state   <= stateNext;
         counter <= counterNext;
      end
   end

   // Next-state logic: IDLE arms the counter, WAIT counts down, DONE completes in one cycle.
   always_comb begin
      stateNext   = state;
      counterNext = counter;
      case (state)
         IDLE: begin
            if (req) begin
               stateNext   = WAIT;
               counterNext = CW'(WAIT_CYCLES - 1);
            end
         end
         WAIT: begin
            if (counter == '0) begin
               stateNext = DONE;
            end else begin
               counterNext = counter - CW'(1);
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext   = IDLE;
            counterNext = '0;
         end
      endcase
   end

   // Data memory has no reset so its contents survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (storeNow) begin
         mem[wordIdx] <= valRmIn;
      end
   end

   // MEM/WB register: advances when ready, otherwise inserts a write-back bubble and holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbEnOut    <= 1'b0;
         memREnOut  <= 1'b0;
         aluResOut  <= '0;
         memDataOut <= '0;
         destOut    <= '0;
      end else if (ready) begin
         wbEnOut   <= wbEnIn;
         memREnOut <= memREnIn;
         aluResOut <= aluResIn;
         destOut   <= destIn;
         if (loadNow) begin
            memDataOut <= mem[wordIdx];
         end
      end else begin
         wbEnOut <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stage_mem_sram_ctrl.sv
// Directed bench for stage_mem_sram_ctrl: pass-through, stall timing, store/load,
// address wrap, unaligned/dual-request handling and reset mid-access.
module tb_stage_mem_sram_ctrl;

   logic        clk;
   logic        rst;
   logic        wbEnIn;
   logic        memREnIn;
   logic        memWEnIn;
   logic [31:0] aluResIn;
   logic [31:0] valRmIn;
   logic [3:0]  destIn;
   logic        ready;
   logic        wbEnOut;
   logic        memREnOut;
   logic [31:0] aluResOut;
   logic [31:0] memDataOut;
   logic [3:0]  destOut;

   int testCount = 0;
   int failCount = 0;

   stage_mem_sram_ctrl #(
      .DEPTH(64),
      .BASE_ADDR(1024),
      .WAIT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wbEnIn(wbEnIn),
      .memREnIn(memREnIn),
      .memWEnIn(memWEnIn),
      .aluResIn(aluResIn),
      .valRmIn(valRmIn),
      .destIn(destIn),
      .ready(ready),
      .wbEnOut(wbEnOut),
      .memREnOut(memREnOut),
      .aluResOut(aluResOut),
      .memDataOut(memDataOut),
      .destOut(destOut)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wbEn, input logic memR, input logic memW,
                                input logic [31:0] alu, input logic [31:0] valRm,
                                input logic [3:0] dest);
      wbEnIn   = wbEn;
      memREnIn = memR;
      memWEnIn = memW;
      aluResIn = alu;
      valRmIn  = valRm;
      destIn   = dest;
   endtask

   // Drives a mem op right after a rising edge and walks it through the 4+1 stall
   // cycles plus the DONE cycle, checking ready and the bubble each cycle.
   // Returns 1 ns after the DONE edge, with inputs still held.
   task automatic runAccess(input string tag, input logic wbEn, input logic memR,
                            input logic memW, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] dest);
      applyStimulus(wbEn, memR, memW, addr, data, dest);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s ready c%0d", tag, i), {31'd0, ready}, (i < 5) ? 32'd0 : 32'd1);
         if (i >= 1) begin
            checkOutput($sformatf("%s bubble c%0d", tag, i), {31'd0, wbEnOut}, 32'd0);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      #12;
      checkOutput("reset wbEnOut", {31'd0, wbEnOut}, 32'd0);
      checkOutput("reset memREnOut", {31'd0, memREnOut}, 32'd0);
      checkOutput("reset aluResOut", aluResOut, 32'd0);
      checkOutput("reset memDataOut", memDataOut, 32'd0);
      checkOutput("reset destOut", {28'd0, destOut}, 32'd0);
      checkOutput("reset ready", {31'd0, ready}, 32'd1);
      rst = 1'b1;

      // ALU op passes through with one-cycle latency and no stall
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 4'd3);
      @(negedge clk);
      checkOutput("alu ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("alu wbEnOut", {31'd0, wbEnOut}, 32'd1);
      checkOutput("alu aluResOut", aluResOut, 32'h5);
      checkOutput("alu destOut", {28'd0, destOut}, 32'd3);
      checkOutput("alu memREnOut", {31'd0, memREnOut}, 32'd0);

      // Store 0xDEADBEEF to word 1, then load it straight back
      runAccess("st1028", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
      checkOutput("st1028 wbEnOut", {31'd0, wbEnOut}, 32'd0);
      checkOutput("st1028 aluResOut", aluResOut, 32'd1028);
      runAccess("ld1028", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5);
      checkOutput("ld1028 memDataOut", memDataOut, 32'hDEADBEEF);
      checkOutput("ld1028 memREnOut", {31'd0, memREnOut}, 32'd1);
      checkOutput("ld1028 wbEnOut", {31'd0, wbEnOut}, 32'd1);
      checkOutput("ld1028 destOut", {28'd0, destOut}, 32'd5);

      // Address one past the end wraps to word 0
      runAccess("st1280", 1'b0, 1'b0, 1'b1, 32'd1280, 32'h1234, 4'd0);
      runAccess("ld1024", 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd6);
      checkOutput("ld1024 memDataOut", memDataOut, 32'h1234);

      // Both enables set acts as a store at an unaligned address; load data holds
      runAccess("both1031", 1'b1, 1'b1, 1'b1, 32'd1031, 32'hCAFEF00D, 4'd7);
      checkOutput("both1031 memREnOut", {31'd0, memREnOut}, 32'd1);
      checkOutput("both1031 memDataOut hold", memDataOut, 32'h1234);
      checkOutput("both1031 destOut", {28'd0, destOut}, 32'd7);
      runAccess("ld1029", 1'b1, 1'b1, 1'b0, 32'd1029, 32'h0, 4'd8);
      checkOutput("ld1029 memDataOut", memDataOut, 32'hCAFEF00D);

      // Preload word 2, then abort a second store to it with reset
      runAccess("st1032", 1'b0, 1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 4'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd1032, 32'h55555555, 4'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      #1;
      checkOutput("abort wbEnOut", {31'd0, wbEnOut}, 32'd0);
      checkOutput("abort aluResOut", aluResOut, 32'd0);
      checkOutput("abort memDataOut", memDataOut, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort ready after release", {31'd0, ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
      end
      #1;
      runAccess("ld1032", 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd9);
      checkOutput("ld1032 memDataOut", memDataOut, 32'hA5A5A5A5);

      // Non-memory op right after an access still has no stall
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd10);
      @(negedge clk);
      checkOutput("alu2 ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("alu2 aluResOut", aluResOut, 32'h77);
      checkOutput("alu2 memREnOut", {31'd0, memREnOut}, 32'd0);
      checkOutput("alu2 memDataOut hold", memDataOut, 32'hA5A5A5A5);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
